// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default width, FSM states and
// iteration counter sizing.
package divider_seq_pkg;

    localparam int unsigned DefWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must hold 0..WIDTH.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/subtractor_nbit.sv
// Ripple subtractor: a + ~b + 1 built from full-adder cells.
// no_borrow_o is the final carry, so it is 1 when a >= b.
module subtractor_nbit #(
    parameter int unsigned Width = 5
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] diff_o,
    output logic             no_borrow_o
);

    logic [Width:0]   carry;
    logic [Width-1:0] b_inv;

    assign b_inv    = ~b_i;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < Width; i++) begin : g_cell
        assign diff_o[i]    = a_i[i] ^ b_inv[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_inv[i]) | (carry[i] & (a_i[i] ^ b_inv[i]));
    end

    assign no_borrow_o = carry[Width];

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring unsigned divider: one quotient bit per clock with a
// start/busy/done handshake. Divide by zero completes in one cycle.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH:0]   trial_diff;
    logic             no_borrow;
    logic             accept;
    logic             unused_diff_msb;

    // Partial remainder stays below the divisor, so it fits in WIDTH bits between steps;
    // only the shifted value needs the extra bit.
    assign shift_rem       = {rem_q, quo_q[WIDTH-1]};
    assign unused_diff_msb = trial_diff[WIDTH];

    subtractor_nbit #(
        .Width(WIDTH + 1)
    ) u_sub (
        .a_i        (shift_rem),
        .b_i        ({1'b0, dvs_q}),
        .diff_o     (trial_diff),
        .no_borrow_o(no_borrow)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        accept      = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = i_start;
            end
            StRun: begin
                quo_d = {quo_q[WIDTH-2:0], no_borrow};
                rem_d = no_borrow ? trial_diff[WIDTH-1:0] : shift_rem[WIDTH-1:0];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = StDone;
                    cnt_d       = '0;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                end
            end
            StDone: begin
                state_d = StIdle;
                accept  = i_start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            dvs_d = i_divisor;
            dbz_d = 1'b0;
            cnt_d = '0;
            if (i_divisor == '0) begin
                state_d     = StDone;
                quotient_d  = '1;
                remainder_d = i_dividend;
                dbz_d       = 1'b1;
            end else begin
                state_d     = StRun;
                rem_d       = '0;
                quo_d       = i_dividend;
                quotient_d  = '0;
                remainder_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign o_busy        = (state_q == StRun);
    assign o_done        = (state_q == StDone);
    assign o_quotient    = quotient_q;
    assign o_remainder   = remainder_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed scenarios, exhaustive 4-bit sweep and
// random operations, checked against plain / and % arithmetic.
module tb_divider_seq;

    localparam int unsigned W = 4;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_start;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int checks = 0;
    int passed = 0;

    divider_seq #(
        .WIDTH(W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    // Reference results straight from integer arithmetic.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        if (bi == 0) return '1;
        return W'(ai / bi);
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        if (bi == 0) return a;
        return W'(ai % bi);
    endfunction

    // Called at a negedge: present a request for the next rising edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
    endtask

    // Follows an accepted request until o_done, scrambling inputs while it runs.
    // Returns at the negedge where o_done is seen, with i_start low.
    task automatic wait_check(input logic [W-1:0] a, input logic [W-1:0] b);
        string tag;
        int    cyc;
        int    lat_exp;
        bit    seen;
        bit    busy_ok;
        int unsigned prod;
        tag     = $sformatf("%0d/%0d", a, b);
        lat_exp = (b == 0) ? 1 : W + 1;
        cyc     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cyc < int'(W) + 4) begin
            @(negedge i_clk);
            cyc++;
            if (cyc == 1 && b != 0)
                chk({tag, " cleared"}, {23'd0, o_quotient, o_remainder, o_div_by_zero}, 32'd0);
            if (o_done) begin
                seen = 1'b1;
            end else begin
                if (o_busy !== 1'b1) busy_ok = 1'b0;
                i_start    = 1'($urandom_range(0, 1));
                i_dividend = W'($urandom_range(0, 15));
                i_divisor  = W'($urandom_range(0, 15));
            end
        end
        i_start = 1'b0;
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(lat_exp));
        chk({tag, " busy during run"}, 32'(busy_ok), 32'd1);
        chk({tag, " busy at done"}, 32'(o_busy), 32'd0);
        chk({tag, " quotient"}, 32'(o_quotient), 32'(ref_q(a, b)));
        chk({tag, " remainder"}, 32'(o_remainder), 32'(ref_r(a, b)));
        chk({tag, " div_by_zero"}, 32'(o_div_by_zero), 32'(b == 0));
        if (b != 0) begin
            prod = int'(o_quotient) * int'(b) + int'(o_remainder);
            chk({tag, " invariant"}, 32'(prod == int'(a) && o_remainder < b), 32'd1);
        end
    endtask

    // One idle cycle after done: pulse gone, results held.
    task automatic hold_check(input logic [W-1:0] a, input logic [W-1:0] b);
        string tag;
        tag = $sformatf("%0d/%0d hold", a, b);
        @(negedge i_clk);
        chk({tag, " done"}, 32'(o_done), 32'd0);
        chk({tag, " busy"}, 32'(o_busy), 32'd0);
        chk({tag, " result"}, {23'd0, o_quotient, o_remainder, o_div_by_zero},
            {23'd0, ref_q(a, b), ref_r(a, b), 1'(b == 0)});
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {27'd0, o_busy, o_done, 3'd0} | {23'd0, o_quotient, o_remainder, o_div_by_zero},
            32'd0);
    endtask

    initial begin
        bit          got_done;
        logic [W-1:0] ra, rb;

        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk_all_zero("reset state");
        i_rst_n = 1'b1;

        // Basic divide.
        @(negedge i_clk);
        start_op(4'd13, 4'd4);
        wait_check(4'd13, 4'd4);
        hold_check(4'd13, 4'd4);

        // Back-to-back: second start during first done.
        start_op(4'd15, 4'd1);
        wait_check(4'd15, 4'd1);
        start_op(4'd3, 4'd7);
        wait_check(4'd3, 4'd7);
        hold_check(4'd3, 4'd7);

        // Divide by zero.
        start_op(4'd9, 4'd0);
        wait_check(4'd9, 4'd0);
        hold_check(4'd9, 4'd0);

        // Restart pulse and operand change mid-run are ignored.
        start_op(4'd14, 4'd3);
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        start_op(4'd1, 4'd1);
        @(negedge i_clk);
        i_start = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 4 && !got_done; i++) begin
            if (o_done) got_done = 1'b1;
            else @(negedge i_clk);
        end
        chk("14/3 ignore restart done", 32'(got_done), 32'd1);
        chk("14/3 ignore restart result", {24'd0, o_quotient, o_remainder}, {24'd0, 4'd4, 4'd2});

        // Reset mid-run aborts.
        @(negedge i_clk);
        start_op(4'd12, 4'd5);
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk_all_zero("mid-run reset outputs");
        i_rst_n  = 1'b1;
        got_done = 1'b0;
        repeat (W + 3) begin
            @(negedge i_clk);
            if (o_done || o_busy) got_done = 1'b1;
        end
        chk("mid-run reset no done", 32'(got_done), 32'd0);
        start_op(4'd12, 4'd5);
        wait_check(4'd12, 4'd5);
        hold_check(4'd12, 4'd5);

        // Reset and start together: reset wins.
        i_rst_n = 1'b0;
        start_op(4'd7, 4'd2);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_start = 1'b0;
        chk_all_zero("reset with start");
        @(negedge i_clk);
        chk("reset with start stays idle", {30'd0, o_busy, o_done}, 32'd0);

        // Exhaustive sweep, randomly mixing back-to-back and idle gaps.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(W'(a), W'(b));
                wait_check(W'(a), W'(b));
                if ($urandom_range(0, 1) == 1) hold_check(W'(a), W'(b));
            end
        end

        // Random operations.
        repeat (60) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            start_op(ra, rb);
            wait_check(ra, rb);
            if ($urandom_range(0, 2) == 0) hold_check(ra, rb);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
